// File: rtl/or1420_regfile_pkg.sv
// Shared constants and types for the or1420 register-file write side.
package or1420_regfile_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_ENTRIES    = 32;

  // Last address touched by the post-reset clearing sweep.
  localparam logic [RF_ADDR_WIDTH-1:0] RF_LAST_ADDR = RF_ADDR_WIDTH'(RF_ENTRIES - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Read-after-write bypass for one read port of the bit-sliced register file.
// Priority: hard-wired r0, then the staged RAM write, then the hold buffer, then the RAM itself.
module regfile_bypass_mux
  import or1420_regfile_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]    INIT_VALUE = '0,
  parameter bit                       R0_IS_ZERO = 1'b1
) (
  input  logic [RF_ADDR_WIDTH-1:0] readAddr,
  input  logic                     stagedWe,
  input  logic [RF_ADDR_WIDTH-1:0] stagedAddr,
  input  logic [DATA_WIDTH-1:0]    stagedData,
  input  logic                     bufValid,
  input  logic [RF_ADDR_WIDTH-1:0] bufAddr,
  input  logic [DATA_WIDTH-1:0]    bufData,
  input  logic [DATA_WIDTH-1:0]    ramDataOut,
  output logic [DATA_WIDTH-1:0]    readData
);

  // Pick the youngest visible value for the requested address.
  always_comb begin
    readData = ramDataOut;
    if (R0_IS_ZERO && (readAddr == '0)) begin
      readData = INIT_VALUE;
    end else if (stagedWe && (stagedAddr == readAddr)) begin
      readData = stagedData;
    end else if (bufValid && (bufAddr == readAddr)) begin
      readData = bufData;
    end
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Write-side controller for the or1420 register file: clears all entries after reset, then
// merges execute-stage and load-return writes onto the single registered RAM write port,
// holding at most one displaced load write, and provides bypassed data for two read ports.
module regfile_write_sequencer
  import or1420_regfile_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]    INIT_VALUE = '0,
  parameter bit                       R0_IS_ZERO = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     exWe,
  input  logic [RF_ADDR_WIDTH-1:0] exAddr,
  input  logic [DATA_WIDTH-1:0]    exData,
  input  logic                     memWe,
  input  logic [RF_ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0]    memData,
  output logic                     memReady,
  output logic                     initDone,
  output logic                     ramWe,
  output logic [RF_ADDR_WIDTH-1:0] ramWriteAddr,
  output logic [DATA_WIDTH-1:0]    ramDataIn,
  input  logic [RF_ADDR_WIDTH-1:0] readAddrA,
  input  logic [RF_ADDR_WIDTH-1:0] readAddrB,
  input  logic [DATA_WIDTH-1:0]    ramDataOutA,
  input  logic [DATA_WIDTH-1:0]    ramDataOutB,
  output logic [DATA_WIDTH-1:0]    readDataA,
  output logic [DATA_WIDTH-1:0]    readDataB
);

  rf_state_t                r_state;
  rf_state_t                w_stateNext;
  logic [RF_ADDR_WIDTH-1:0] r_cnt;
  logic [RF_ADDR_WIDTH-1:0] w_cntNext;
  logic                     r_initDone;
  logic                     w_initDoneNext;

  logic                     r_bufValid;
  logic [RF_ADDR_WIDTH-1:0] r_bufAddr;
  logic [DATA_WIDTH-1:0]    r_bufData;
  logic                     w_bufValidNext;
  logic [RF_ADDR_WIDTH-1:0] w_bufAddrNext;
  logic [DATA_WIDTH-1:0]    w_bufDataNext;

  logic                     r_we;
  logic [RF_ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     w_we;
  logic [RF_ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0]    w_wdata;

  logic                     w_memReady;
  logic                     w_exValid;
  logic                     w_memValid;

  assign w_memReady = (r_state == ST_RUN) && !r_bufValid;

  // Address-0 requests are treated as absent when r0 is hard-wired; a load offered while
  // memReady is low is a protocol violation and is simply ignored.
  assign w_exValid  = exWe && !(R0_IS_ZERO && (exAddr == '0));
  assign w_memValid = memWe && w_memReady && !(R0_IS_ZERO && (memAddr == '0));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and write-port arbitration: ex always wins, a concurrent load is parked in the
  // hold buffer, and a younger ex write to the parked address kills the buffered load.
  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_initDoneNext = r_initDone;
    w_bufValidNext = r_bufValid;
    w_bufAddrNext  = r_bufAddr;
    w_bufDataNext  = r_bufData;
    w_we           = 1'b0;
    w_waddr        = r_waddr;
    w_wdata        = r_wdata;
    unique case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = INIT_VALUE;
        if (r_cnt == RF_LAST_ADDR) begin
          w_stateNext    = ST_RUN;
          w_initDoneNext = 1'b1;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (w_exValid) begin
          w_we    = 1'b1;
          w_waddr = exAddr;
          w_wdata = exData;
          if (r_bufValid) begin
            if (r_bufAddr == exAddr) begin
              w_bufValidNext = 1'b0;
            end
          end else if (w_memValid && (memAddr != exAddr)) begin
            w_bufValidNext = 1'b1;
            w_bufAddrNext  = memAddr;
            w_bufDataNext  = memData;
          end
        end else if (r_bufValid) begin
          w_we           = 1'b1;
          w_waddr        = r_bufAddr;
          w_wdata        = r_bufData;
          w_bufValidNext = 1'b0;
        end else if (w_memValid) begin
          w_we    = 1'b1;
          w_waddr = memAddr;
          w_wdata = memData;
        end
      end
      default: begin
        w_stateNext = ST_INIT;
      end
    endcase
  end

  // Sweep counter, hold buffer, init flag and the registered RAM write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_initDone <= 1'b0;
      r_bufValid <= 1'b0;
      r_bufAddr  <= '0;
      r_bufData  <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_cnt      <= w_cntNext;
      r_initDone <= w_initDoneNext;
      r_bufValid <= w_bufValidNext;
      r_bufAddr  <= w_bufAddrNext;
      r_bufData  <= w_bufDataNext;
      r_we       <= w_we;
      r_waddr    <= w_waddr;
      r_wdata    <= w_wdata;
    end
  end

  assign memReady     = w_memReady;
  assign initDone     = r_initDone;
  assign ramWe        = r_we;
  assign ramWriteAddr = r_waddr;
  assign ramDataIn    = r_wdata;

  regfile_bypass_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_VALUE (INIT_VALUE),
    .R0_IS_ZERO (R0_IS_ZERO)
  ) u_bypassA (
    .readAddr   (readAddrA),
    .stagedWe   (r_we),
    .stagedAddr (r_waddr),
    .stagedData (r_wdata),
    .bufValid   (r_bufValid),
    .bufAddr    (r_bufAddr),
    .bufData    (r_bufData),
    .ramDataOut (ramDataOutA),
    .readData   (readDataA)
  );

  regfile_bypass_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_VALUE (INIT_VALUE),
    .R0_IS_ZERO (R0_IS_ZERO)
  ) u_bypassB (
    .readAddr   (readAddrB),
    .stagedWe   (r_we),
    .stagedAddr (r_waddr),
    .stagedData (r_wdata),
    .bufValid   (r_bufValid),
    .bufAddr    (r_bufAddr),
    .bufData    (r_bufData),
    .ramDataOut (ramDataOutB),
    .readData   (readDataB)
  );

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer; a behavioural 32-entry RAM stands in for the
// lutRam32x1 slices so reads can be observed end to end.
module tb_regfile_write_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exWe = 1'b0;
  logic [4:0]  exAddr = '0;
  logic [31:0] exData = '0;
  logic        memWe = 1'b0;
  logic [4:0]  memAddr = '0;
  logic [31:0] memData = '0;
  logic        memReady;
  logic        initDone;
  logic        ramWe;
  logic [4:0]  ramWriteAddr;
  logic [31:0] ramDataIn;
  logic [4:0]  readAddrA = '0;
  logic [4:0]  readAddrB = '0;
  logic [31:0] ramDataOutA;
  logic [31:0] ramDataOutB;
  logic [31:0] readDataA;
  logic [31:0] readDataB;

  logic [31:0] ram [32];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  regfile_write_sequencer #(
    .DATA_WIDTH (32),
    .INIT_VALUE (32'h0),
    .R0_IS_ZERO (1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .exWe         (exWe),
    .exAddr       (exAddr),
    .exData       (exData),
    .memWe        (memWe),
    .memAddr      (memAddr),
    .memData      (memData),
    .memReady     (memReady),
    .initDone     (initDone),
    .ramWe        (ramWe),
    .ramWriteAddr (ramWriteAddr),
    .ramDataIn    (ramDataIn),
    .readAddrA    (readAddrA),
    .readAddrB    (readAddrB),
    .ramDataOutA  (ramDataOutA),
    .ramDataOutB  (ramDataOutB),
    .readDataA    (readDataA),
    .readDataB    (readDataB)
  );

  always #5 clock = ~clock;

  // RAM model: synchronous write, asynchronous read, two read copies.
  always @(posedge clock) begin
    if (ramWe) ram[ramWriteAddr] <= ramDataIn;
  end
  assign ramDataOutA = ram[readAddrA];
  assign ramDataOutB = ram[readAddrB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    exWe  = 1'b0;
    memWe = 1'b0;
  endtask

  // Release reset just after an edge and check the full 32-entry clearing sweep.
  task automatic release_and_sweep(input string tag);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      chk({tag, "_we"},   {31'b0, ramWe}, 32'd1);
      chk({tag, "_addr"}, {27'b0, ramWriteAddr}, 32'(i));
      chk({tag, "_data"}, ramDataIn, 32'h0);
      chk({tag, "_done"}, {31'b0, initDone}, (i == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'hBAD0_0000 + 32'(i);

    // Reset state
    #12;
    chk("rst_we",    {31'b0, ramWe}, 32'd0);
    chk("rst_addr",  {27'b0, ramWriteAddr}, 32'd0);
    chk("rst_data",  ramDataIn, 32'h0);
    chk("rst_done",  {31'b0, initDone}, 32'd0);
    chk("rst_ready", {31'b0, memReady}, 32'd0);

    // 1: clearing sweep, then all reads are zero
    release_and_sweep("sweep1");
    chk("sweep1_ready", {31'b0, memReady}, 32'd1);
    for (int i = 0; i < 32; i += 5) begin
      readAddrA = 5'(i);
      readAddrB = 5'(31 - i);
      #1;
      chk("zeroA", readDataA, 32'h0);
      chk("zeroB", readDataB, 32'h0);
    end
    step();
    chk("post_sweep_we", {31'b0, ramWe}, 32'd0);

    // 2: ex r3 and mem r7 in the same cycle
    exWe = 1'b1; exAddr = 5'd3; exData = 32'hAAAA_0001;
    memWe = 1'b1; memAddr = 5'd7; memData = 32'h0000_5555;
    step();
    idle_inputs();
    chk("t2_we0",   {31'b0, ramWe}, 32'd1);
    chk("t2_addr0", {27'b0, ramWriteAddr}, 32'd3);
    chk("t2_data0", ramDataIn, 32'hAAAA_0001);
    chk("t2_ready0", {31'b0, memReady}, 32'd0);
    readAddrA = 5'd7; readAddrB = 5'd3; #1;
    chk("t2_bufbyp", readDataA, 32'h0000_5555);
    chk("t2_stgbyp", readDataB, 32'hAAAA_0001);
    step();
    chk("t2_we1",   {31'b0, ramWe}, 32'd1);
    chk("t2_addr1", {27'b0, ramWriteAddr}, 32'd7);
    chk("t2_data1", ramDataIn, 32'h0000_5555);
    chk("t2_ready1", {31'b0, memReady}, 32'd1);
    step();
    chk("t2_we2", {31'b0, ramWe}, 32'd0);
    chk("t2_r7", readDataA, 32'h0000_5555);
    chk("t2_r3", readDataB, 32'hAAAA_0001);

    // 3: ex and mem both to r9, ex wins and buffer stays empty
    exWe = 1'b1; exAddr = 5'd9; exData = 32'h11;
    memWe = 1'b1; memAddr = 5'd9; memData = 32'h22;
    step();
    idle_inputs();
    chk("t3_data",  ramDataIn, 32'h11);
    chk("t3_ready", {31'b0, memReady}, 32'd1);
    step();
    chk("t3_we1", {31'b0, ramWe}, 32'd0);
    readAddrA = 5'd9; #1;
    chk("t3_r9", readDataA, 32'h11);

    // 4: buffered mem r5 killed by younger ex r5
    exWe = 1'b1; exAddr = 5'd6; exData = 32'h66;
    memWe = 1'b1; memAddr = 5'd5; memData = 32'h33;
    step();
    chk("t4_ready0", {31'b0, memReady}, 32'd0);
    memWe = 1'b0; exAddr = 5'd5; exData = 32'h44;
    step();
    idle_inputs();
    chk("t4_addr",  {27'b0, ramWriteAddr}, 32'd5);
    chk("t4_data",  ramDataIn, 32'h44);
    chk("t4_ready1", {31'b0, memReady}, 32'd1);
    step();
    chk("t4_we2", {31'b0, ramWe}, 32'd0);
    readAddrA = 5'd5; readAddrB = 5'd6;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_r5", readDataA, 32'h44);
    end
    chk("t4_r6", readDataB, 32'h66);

    // 5: staging bypass and hard-wired r0
    exWe = 1'b1; exAddr = 5'd12; exData = 32'hDEAD_BEEF;
    step();
    exAddr = 5'd0; exData = 32'hFFFF_FFFF;
    readAddrA = 5'd12; readAddrB = 5'd0; #1;
    chk("t5_rawold", ramDataOutA, 32'h0);
    chk("t5_byp12", readDataA, 32'hDEAD_BEEF);
    step();
    idle_inputs();
    chk("t5_r0we", {31'b0, ramWe}, 32'd0);
    chk("t5_r0", readDataB, 32'h0);
    step();
    chk("t5_r0b", readDataB, 32'h0);
    chk("t5_r12", readDataA, 32'hDEAD_BEEF);

    // 6: reset mid-sweep with exWe held
    exWe = 1'b1; exAddr = 5'd4; exData = 32'h1234_5678;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 18; i++) step();
    chk("t6_at17", {27'b0, ramWriteAddr}, 32'd17);
    reset = 1'b1; #1;
    chk("t6_rst_we",   {31'b0, ramWe}, 32'd0);
    chk("t6_rst_done", {31'b0, initDone}, 32'd0);
    release_and_sweep("sweep2");
    idle_inputs();
    readAddrA = 5'd4; #1;
    chk("t6_r4", readDataA, 32'h0);
    step();
    chk("t6_r4b", readDataA, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
